// File: rtl/dm_bus_arbiter_pkg.sv
// dm_bus_arbiter_pkg
//   Shared definitions for the debug-module bus arbiter: bus field widths,
//   the read pattern returned on a watchdog-forced completion, and the
//   FSM state encoding.
package dm_bus_arbiter_pkg;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] BUS_ERR_RDATA = 32'hFFFF_FFFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/dm_bus_arbiter_rr_pick.sv
// dm_bus_arbiter_rr_pick
//   Combinational round-robin picker. Scans req starting at ptr and moving
//   upward with wrap-around; the first set bit wins.
// Ports:
//   req    in  N      request vector
//   ptr    in  IDX_W  starting index of the scan (must be < N)
//   winner out IDX_W  index of the selected requester (0 when none)
//   any    out 1      at least one request is set
module dm_bus_arbiter_rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any
);

   // Walk offsets from farthest to nearest so the nearest set bit is the
   // last one written and therefore wins.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            winner = IDX_W'((int'(ptr) + i) % N);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter
//   Shares the debug module's single hart-side bus port among NUM_HART
//   debug-ROM requesters. Round-robin, one outstanding transaction, request
//   fields latched at grant. Optional watchdog forces an error completion.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no transaction; arbitrate among s_bus_valid, m_bus_valid low
//   ST_BUSY | granted transaction on m_bus_*, waiting for m_bus_ready/timeout
//
// Ports:
//   clk, resetn               clock, async active-low reset
//   s_bus_valid/write         per-hart request valid / write flag
//   s_bus_addr/wdata          per-hart packed address / write data
//   s_bus_ready               per-hart completion pulse (one-hot or zero)
//   s_bus_rdata               shared read data, valid with s_bus_ready
//   m_bus_*                   downstream debug-module bus port
//   grant_idx                 current or last granted hart
//   timeout_err               one-cycle pulse when the watchdog fires
module dm_bus_arbiter
   import dm_bus_arbiter_pkg::*;
#(
   parameter int NUM_HART = 2,
   parameter int TIMEOUT  = 0,
   parameter int IDX_W    = (NUM_HART > 1) ? $clog2(NUM_HART) : 1
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_HART-1:0]        s_bus_valid,
   output logic [NUM_HART-1:0]        s_bus_ready,
   input  logic [NUM_HART-1:0]        s_bus_write,
   input  logic [NUM_HART*ADDR_W-1:0] s_bus_addr,
   input  logic [NUM_HART*DATA_W-1:0] s_bus_wdata,
   output logic [DATA_W-1:0]          s_bus_rdata,
   output logic                       m_bus_valid,
   input  logic                       m_bus_ready,
   output logic                       m_bus_write,
   output logic [ADDR_W-1:0]          m_bus_addr,
   output logic [DATA_W-1:0]          m_bus_wdata,
   input  logic [DATA_W-1:0]          m_bus_rdata,
   output logic [IDX_W-1:0]           grant_idx,
   output logic                       timeout_err
);

   localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int WD_TC = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [WD_W-1:0]   wd_cnt;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic              done_ok;
   logic              wd_fire;
   logic              complete;

   dm_bus_arbiter_rr_pick #(
      .N     (NUM_HART),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req    (s_bus_valid),
      .ptr    (rr_ptr),
      .winner (pick_idx),
      .any    (pick_any)
   );

   // A downstream ready in the timeout cycle takes priority: wd_fire
   // requires m_bus_ready low.
   assign done_ok  = (state == ST_BUSY) && m_bus_valid && m_bus_ready;
   assign wd_fire  = (TIMEOUT > 0) && (state == ST_BUSY) && !m_bus_ready &&
                     (wd_cnt == WD_W'(WD_TC));
   assign complete = done_ok || wd_fire;

   assign timeout_err = wd_fire;
   assign s_bus_rdata = wd_fire ? BUS_ERR_RDATA : m_bus_rdata;

   always_comb begin
      s_bus_ready = '0;
      for (int i = 0; i < NUM_HART; i++) begin
         if (complete && (grant_idx == IDX_W'(i))) s_bus_ready[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         grant_idx   <= '0;
         m_bus_valid <= 1'b0;
         m_bus_write <= 1'b0;
         m_bus_addr  <= '0;
         m_bus_wdata <= '0;
         wd_cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant_idx   <= pick_idx;
                  m_bus_write <= s_bus_write[pick_idx];
                  m_bus_addr  <= s_bus_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                  m_bus_wdata <= s_bus_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                  m_bus_valid <= 1'b1;
                  wd_cnt      <= '0;
                  state       <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (complete) begin
                  // Dropping valid for a cycle lets the debug module's
                  // ready toggle re-arm before the next transaction.
                  m_bus_valid <= 1'b0;
                  rr_ptr      <= (grant_idx == IDX_W'(NUM_HART - 1)) ?
                                 '0 : grant_idx + 1'b1;
                  state       <= ST_IDLE;
               end else if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
module tb_dm_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  s_bus_valid;
   logic [1:0]  s_bus_ready;
   logic [1:0]  s_bus_write;
   logic [39:0] s_bus_addr;
   logic [63:0] s_bus_wdata;
   logic [31:0] s_bus_rdata;
   logic        m_bus_valid;
   logic        m_bus_ready;
   logic        m_bus_write;
   logic [19:0] m_bus_addr;
   logic [31:0] m_bus_wdata;
   logic [31:0] m_bus_rdata;
   logic [0:0]  grant_idx;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   dm_bus_arbiter #(
      .NUM_HART (2),
      .TIMEOUT  (8)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .s_bus_valid (s_bus_valid),
      .s_bus_ready (s_bus_ready),
      .s_bus_write (s_bus_write),
      .s_bus_addr  (s_bus_addr),
      .s_bus_wdata (s_bus_wdata),
      .s_bus_rdata (s_bus_rdata),
      .m_bus_valid (m_bus_valid),
      .m_bus_ready (m_bus_ready),
      .m_bus_write (m_bus_write),
      .m_bus_addr  (m_bus_addr),
      .m_bus_wdata (m_bus_wdata),
      .m_bus_rdata (m_bus_rdata),
      .grant_idx   (grant_idx),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [0:0] fair_exp [4];
      fair_exp[0] = 1'b0; fair_exp[1] = 1'b1; fair_exp[2] = 1'b0; fair_exp[3] = 1'b1;

      resetn      = 1'b0;
      s_bus_valid = '0;
      s_bus_write = '0;
      s_bus_addr  = '0;
      s_bus_wdata = '0;
      m_bus_ready = 1'b0;
      m_bus_rdata = '0;

      // Reset state
      #2;
      chk("rst_m_valid", 32'(m_bus_valid), 32'd0);
      chk("rst_s_ready", 32'(s_bus_ready), 32'd0);
      chk("rst_grant",   32'(grant_idx),   32'd0);
      chk("rst_m_addr",  32'(m_bus_addr),  32'd0);
      chk("rst_m_write", 32'(m_bus_write), 32'd0);
      chk("rst_terr",    32'(timeout_err), 32'd0);
      step(); step();
      #2 resetn = 1'b1;
      step();

      // Single read by hart0
      s_bus_valid = 2'b01;
      s_bus_addr[19:0] = 20'h00400;
      #1 chk("rd_m_valid_pre", 32'(m_bus_valid), 32'd0);
      step();
      chk("rd_m_valid",    32'(m_bus_valid), 32'd1);
      chk("rd_m_addr",     32'(m_bus_addr),  32'h400);
      chk("rd_m_write",    32'(m_bus_write), 32'd0);
      chk("rd_grant",      32'(grant_idx),   32'd0);
      chk("rd_s_ready_w",  32'(s_bus_ready), 32'd0);
      step();
      m_bus_ready = 1'b1;
      m_bus_rdata = 32'h1234_5678;
      #1;
      chk("rd_s_ready",    32'(s_bus_ready), 32'h1);
      chk("rd_s_rdata",    s_bus_rdata,      32'h1234_5678);
      step();
      s_bus_valid = 2'b00;
      m_bus_ready = 1'b0;
      #1;
      chk("rd_gap_valid",  32'(m_bus_valid), 32'd0);
      chk("rd_gap_ready",  32'(s_bus_ready), 32'd0);

      // Back to rr_ptr=0 for the simultaneous-write case
      #2 resetn = 1'b0;
      step();
      #2 resetn = 1'b1;
      s_bus_valid = 2'b11;
      s_bus_write = 2'b11;
      s_bus_wdata = {32'h0000_000B, 32'h0000_000A};
      step();
      chk("sim_grant0",  32'(grant_idx),   32'd0);
      chk("sim_wdata0",  m_bus_wdata,      32'hA);
      chk("sim_write0",  32'(m_bus_write), 32'd1);
      m_bus_ready = 1'b1;
      #1 chk("sim_ready0", 32'(s_bus_ready), 32'h1);
      step();
      s_bus_valid = 2'b10;
      m_bus_ready = 1'b0;
      #1 chk("sim_gap", 32'(m_bus_valid), 32'd0);
      step();
      chk("sim_grant1",  32'(grant_idx),   32'd1);
      chk("sim_wdata1",  m_bus_wdata,      32'hB);
      m_bus_ready = 1'b1;
      #1 chk("sim_ready1", 32'(s_bus_ready), 32'h2);
      step();
      s_bus_valid = 2'b00;
      s_bus_write = 2'b00;
      m_bus_ready = 1'b0;

      // Fairness: both harts keep requesting
      s_bus_valid = 2'b11;
      for (int t = 0; t < 4; t++) begin
         step();
         chk("fair_grant", 32'(grant_idx), 32'(fair_exp[t]));
         m_bus_ready = 1'b1;
         #1 chk("fair_ready", 32'(s_bus_ready), 32'(2'b01 << fair_exp[t]));
         step();
         m_bus_ready = 1'b0;
      end
      s_bus_valid = 2'b00;
      step();

      // Stable latch: hart1 changes its address after grant
      s_bus_valid = 2'b10;
      s_bus_addr[39:20] = 20'h00404;
      step();
      chk("lat_grant", 32'(grant_idx),  32'd1);
      chk("lat_addr0", 32'(m_bus_addr), 32'h404);
      s_bus_addr[39:20] = 20'h00408;
      for (int t = 0; t < 5; t++) begin
         step();
         chk("lat_addr",  32'(m_bus_addr),  32'h404);
         chk("lat_valid", 32'(m_bus_valid), 32'd1);
      end
      m_bus_ready = 1'b1;
      m_bus_rdata = 32'hCAFE_0001;
      #1;
      chk("lat_ready", 32'(s_bus_ready), 32'h2);
      chk("lat_terr",  32'(timeout_err), 32'd0);
      step();
      s_bus_valid = 2'b00;
      m_bus_ready = 1'b0;

      // Watchdog: downstream never ready
      s_bus_valid = 2'b01;
      m_bus_rdata = 32'hDEAD_BEEF;
      step();
      for (int t = 0; t < 7; t++) begin
         chk("wd_wait_ready", 32'(s_bus_ready), 32'd0);
         chk("wd_wait_terr",  32'(timeout_err), 32'd0);
         step();
      end
      chk("wd_fire_ready", 32'(s_bus_ready), 32'h1);
      chk("wd_fire_rdata", s_bus_rdata,      32'hFFFF_FFFF);
      chk("wd_fire_terr",  32'(timeout_err), 32'd1);
      step();
      s_bus_valid = 2'b00;
      #1;
      chk("wd_idle_valid", 32'(m_bus_valid), 32'd0);
      chk("wd_idle_terr",  32'(timeout_err), 32'd0);
      chk("wd_idle_rdata", s_bus_rdata,      32'hDEAD_BEEF);

      // Async reset while BUSY (rr_ptr=1 after the watchdog on hart0)
      s_bus_valid = 2'b10;
      step();
      chk("ar_grant", 32'(grant_idx), 32'd1);
      m_bus_ready = 1'b1;
      #1 chk("ar_ready_pre", 32'(s_bus_ready), 32'h2);
      #1 resetn = 1'b0;
      #1;
      chk("ar_m_valid", 32'(m_bus_valid), 32'd0);
      chk("ar_s_ready", 32'(s_bus_ready), 32'd0);
      chk("ar_grant0",  32'(grant_idx),   32'd0);
      m_bus_ready = 1'b0;
      s_bus_valid = 2'b11;
      s_bus_write = 2'b01;
      s_bus_wdata = {32'h0000_0022, 32'h0000_0011};
      #1 resetn = 1'b1;
      step();
      chk("ar_post_grant", 32'(grant_idx),   32'd0);
      chk("ar_post_valid", 32'(m_bus_valid), 32'd1);
      chk("ar_post_wdata", m_bus_wdata,      32'h11);
      m_bus_ready = 1'b1;
      #1 chk("ar_post_ready", 32'(s_bus_ready), 32'h1);
      step();
      m_bus_ready = 1'b0;
      s_bus_valid = 2'b00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Shares the debug module's single hart-side bus port (valid/ready/write/addr/wdata/rdata) among NUM_HART hart debug-ROM requesters.
- Uses round-robin arbitration with one outstanding transaction at a time.
- Latches the granted request's fields, so the downstream port sees stable signals for the whole transaction.
- Includes an optional watchdog that completes a stalled transaction with an error response.
- Sits between the hart cores and the debug module; the debug module's bus port connects directly to the m_bus_* side.

Parameters:
- NUM_HART, 2: number of requesting harts (>=1).
- TIMEOUT, 0: cycles in BUSY without m_bus_ready before forced completion; 0 disables the watchdog.
- IDX_W, (NUM_HART>1 ? $clog2(NUM_HART) : 1): width of the hart index (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- s_bus_valid  in  NUM_HART  per-hart request valid; held until that hart's ready.
- s_bus_ready  out  NUM_HART  per-hart completion pulse; one-hot or zero.
- s_bus_write  in  NUM_HART  per-hart write flag.
- s_bus_addr  in  NUM_HART*20  per-hart address; hart i in bits [20*i+19:20*i].
- s_bus_wdata  in  NUM_HART*32  per-hart write data, packed the same way.
- s_bus_rdata  out  32  read data, shared by all harts; meaningful only with s_bus_ready.
- m_bus_valid  out  1  to the debug module bus_valid.
- m_bus_ready  in  1  from the debug module bus_ready.
- m_bus_write  out  1  latched write flag.
- m_bus_addr  out  20  latched address.
- m_bus_wdata  out  32  latched write data.
- m_bus_rdata  in  32  from the debug module bus_rdata.
- grant_idx  out  IDX_W  index of the current or last granted hart (observability).
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values (async, resetn=0):
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - m_bus_valid=0, m_bus_write=0, m_bus_addr=0, m_bus_wdata=0.
  - s_bus_ready=0, timeout_err=0, wd_cnt=0.
- FSM states: IDLE and BUSY.
- IDLE:
  - If any s_bus_valid is set, pick the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_HART-1, 0, …).
  - On that edge: grant_idx<=winner; latch winner's write/addr/wdata into the m_bus_* registers; m_bus_valid<=1; wd_cnt<=0; state<=BUSY.
  - Arbitration latency: one cycle from s_bus_valid to m_bus_valid.
- BUSY:
  - m_bus_valid=1 and the m_bus_* fields stay stable; the s_bus_* inputs are ignored.
- Completion (BUSY and m_bus_valid && m_bus_ready):
  - s_bus_ready[grant_idx]=1 combinationally in that same cycle; s_bus_rdata=m_bus_rdata.
  - On the edge: m_bus_valid<=0; rr_ptr<=(grant_idx==NUM_HART-1)?0:grant_idx+1; state<=IDLE.
- Gap between transactions:
  - m_bus_valid is always low for at least one cycle, so the debug module's ready toggle (which clears on match) re-arms.
  - Back-to-back throughput: one transaction per (downstream latency + 2) cycles.
- Watchdog (TIMEOUT>0):
  - wd_cnt increments every BUSY cycle without m_bus_ready.
  - When wd_cnt==TIMEOUT-1 and m_bus_ready=0: s_bus_ready[grant_idx]=1, s_bus_rdata=32'hFFFF_FFFF, timeout_err=1 (all combinational, this cycle).
  - Then rr_ptr advances and state<=IDLE exactly as in a normal completion.
  - If m_bus_ready and the timeout coincide, normal completion wins and timeout_err stays 0.
  - wd_cnt width is $clog2(TIMEOUT+1), saturating; unused when TIMEOUT=0.
- Outside completion: s_bus_ready=0 and s_bus_rdata=m_bus_rdata.
- Requester drops s_bus_valid while granted: protocol violation; the transaction still completes on the latched values and the ready pulse is still issued.
- A request arriving in the same cycle as a completion is considered in the following IDLE cycle.
- The same hart requesting continuously yields to any other pending hart (fairness): the maximum wait is NUM_HART-1 transactions.
- NUM_HART=1: rr_ptr stays 0 and the arbiter degenerates to a register slice plus the idle gap.
- Reset asserted mid-transaction: the FSM and outputs return to reset values immediately; the in-flight transaction is dropped and no ready pulse is given.

Decomposition:
- Shared package/header gets:
  - bus field widths: ADDR_W=20, DATA_W=32;
  - the error read pattern BUS_ERR_RDATA=32'hFFFF_FFFF;
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1.
- Submodule rr_pick (combinational, parameter N):
  - inputs: request vector, rr_ptr;
  - outputs: winner index, any.
- The FSM, latches, and watchdog stay in dm_bus_arbiter.

Test Plan:
- Single read: hart0 reads addr 20'h400, downstream ready 1 cycle after valid with rdata 32'h1234_5678 → m_bus_valid rises 1 cycle after s_bus_valid[0]; s_bus_ready=2'b01 with s_bus_rdata=32'h1234_5678; m_bus_valid low next cycle.
- Simultaneous requests: harts 0 and 1 write 32'hA and 32'hB at cycle 0, rr_ptr=0 → hart0 served first, then hart1; m_bus_wdata sequence is 32'hA then 32'hB; grant_idx 0 then 1.
- Fairness: hart0 re-requests immediately after each ready while hart1 holds a request → grants alternate 0,1,0,1 over 4 transactions.
- Stable latch: hart1 changes s_bus_addr from 20'h404 to 20'h408 after grant, downstream ready delayed 5 cycles → m_bus_addr stays 20'h404 until completion.
- Watchdog: TIMEOUT=8, downstream never ready → exactly 8 BUSY cycles, then s_bus_ready[grant]=1, s_bus_rdata=32'hFFFF_FFFF, timeout_err pulses once, FSM returns to IDLE.
- Async reset mid-transaction: resetn low while BUSY → m_bus_valid and s_bus_ready are 0 immediately without waiting for a clock edge; after release, a new request is granted normally from rr_ptr=0.
